stream_reqack_responder: RTL and testbench
==========================================

// Module: stream_reqack_responder
// PURPOSE
//  Buffered source that serves the pull-style req/ack protocol used by the
//  async operator graph. Upstream pushes tokens with valid/ready into a FIFO.
//  A downstream requester (an in_* operator or a consumer) raises req; this
//  block answers with a one-cycle ack and the head token on dout.
//  It replaces the behavioural producer when real stream data drives an arf graph.
// PARAMETERS
//  DATA_WIDTH  32  token width in bits
//  DEPTH       4   FIFO entries; must be a power of 2 and >= 2
//  ADDR_WIDTH  2   log2(DEPTH)
// PORTS
//  clk      in   1           clock; all logic on posedge
//  rst      in   1           synchronous, active-high reset
//  s_valid  in   1           upstream token valid
//  s_ready  out  1           upstream may push; = ~full & ~rst (combinational)
//  s_data   in   DATA_WIDTH  upstream token
//  req      in   1           downstream request (level)
//  ack      out  1           registered one-cycle pulse; dout valid while high
//  dout     out  DATA_WIDTH  registered served token; held until next ack
//  count    out  32          tokens served since reset; wraps at 2^32
//  level    out  ADDR_WIDTH+1  current FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset: ack=0, dout=0, count=0, level=0, rd/wr pointers=0. FIFO contents are discarded.
//   Reset mid-operation drops all queued tokens. If ack was high, it is 0 after the reset edge.
//  Push: occurs at an edge where s_valid & s_ready. s_data is written at wr_ptr and wr_ptr increments mod DEPTH.
//   Pushes while full are not accepted and upstream holds the token.
//   No bypass: when full, s_ready stays 0 even if a pop happens in the same cycle.
//  Serve: at each edge, if req & ~ack & (level!=0), then ack<=1, dout<=mem[rd_ptr],
//   rd_ptr increments mod DEPTH, and count<=count+1. Otherwise ack<=0.
//   ack is never high for two consecutive cycles. Max rate is 1 token per 2 cycles.
//  Latency: a token pushed at edge k into an empty FIFO with req high gives ack=1 after edge k+1.
//   There is no fall-through.
//  Requester contract: the requester samples dout on the rising edge of ack, or on the clk edge where
//   ack=1, and then drops req. If req stays high, the next token is served at the edge
//   after ack falls.
//  Simultaneous push and pop: both take effect and level is unchanged. Data order is strict FIFO.
//  Empty with req high: ack stays 0 and dout holds its last value. Service starts once a token is queued.
//  req dropping while ack is high has no effect on the pulse already issued.
//  level = pushes - pops, kept as a registered counter. Pointers wrap silently.
// TESTING
//  1 Reset: hold rst for 2 cycles -> ack=0, dout=0, count=0, level=0; s_ready=1 after rst drops.
//  2 Single token: req=1, push 0x5 at edge k -> ack=1 for exactly one cycle after edge k+1,
//    dout=0x5, count=1, level=0.
//  3 Full: req=0, push 0,1,2,3 -> level=4, s_ready=0, 5th token (4) stalls. Then raise req and
//    apply the operator handshake -> acks deliver 0,1,2,3,4 in order, with ack low between pulses.
//  4 Wrap and throughput: stream 0..9 into an in->addi(2)->out arf chain -> consumer sees 2..11
//    in order, count=10, pointers have wrapped twice.
//  5 Simultaneous push and pop: level=2, req high, push 0x77 on the serve edge -> level stays 2,
//    0x77 is served third.
//  6 Reset mid-run: level=3, assert rst for 1 cycle -> level=0, ack=0. Then push 0xA -> first ack
//    carries 0xA and none of the old tokens.

Source files
------------

// File: rtl/stream_reqack_responder_if.sv
// Bundle for the upstream valid/ready push side and the downstream req/ack pull side
// of stream_reqack_responder.
interface stream_reqack_responder_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 2
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  req;
  logic                  ack;
  logic [DATA_WIDTH-1:0] dout;
  logic [31:0]           count;
  logic [ADDR_WIDTH:0]   level;

  // Producer/requester side: pushes tokens and raises req.
  modport master (
    output s_valid, s_data, req,
    input  s_ready, ack, dout, count, level
  );

  // Responder side.
  modport slave (
    input  s_valid, s_data, req,
    output s_ready, ack, dout, count, level
  );
endinterface

// File: rtl/stream_reqack_responder.sv
// FIFO-buffered source: tokens pushed with valid/ready are served one at a time to a
// pull-style requester as a registered one-cycle ack plus held dout.
module stream_reqack_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input logic                      clk,
  input logic                      rst,
  stream_reqack_responder_if.slave bus
);

  typedef enum logic {
    SERVE_IDLE,
    SERVE_ACK
  } serve_state_t;

  serve_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [31:0]           count_q;
  logic                  full, push, pop;

  // No bypass: a pop in the same cycle does not open s_ready while full.
  assign full        = (level_q == (ADDR_WIDTH+1)'(DEPTH));
  assign bus.s_ready = ~full & ~rst;
  assign push        = bus.s_valid & bus.s_ready;

  assign bus.ack   = (state_q == SERVE_ACK);
  assign bus.dout  = dout_q;
  assign bus.count = count_q;
  assign bus.level = level_q;

  // The ACK state lasts exactly one cycle, which enforces the gap between pulses.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      SERVE_IDLE: begin
        if (bus.req && (level_q != '0)) begin
          pop     = 1'b1;
          state_d = SERVE_ACK;
        end
      end
      SERVE_ACK: state_d = SERVE_IDLE;
      default:   state_d = SERVE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SERVE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      dout_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
        dout_q  <= mem[rd_ptr];
        count_q <= count_q + 32'd1;
      end
      unique case ({push, pop})
        2'b10:   level_q <= level_q + (ADDR_WIDTH+1)'(1);
        2'b01:   level_q <= level_q - (ADDR_WIDTH+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.s_data;
    end
  end

endmodule

// File: tb/tb_stream_reqack_responder.sv
// Directed bench for stream_reqack_responder: reset, single serve, full stall,
// sustained throughput with wrap, simultaneous push/pop and mid-run reset.
module tb_stream_reqack_responder;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stream_reqack_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  stream_reqack_responder #(
    .DATA_WIDTH(DW),
    .DEPTH     (4),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] push_q [$];
  logic          fire = 1'b0;
  logic          prev_ack = 1'b0;

  always @(posedge clk) fire <= bus.s_valid & bus.s_ready;

  // ack must never be high on two consecutive cycles
  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      checks++;
      if (prev_ack === 1'b1) begin
        errors++;
        $display("FAIL ack_gap: ack high two cycles in a row, got ack=%b prev=%b required prev=0",
                 bus.ack, prev_ack);
      end
    end
    prev_ack = bus.ack;
  end

  task automatic feed();
    bus.s_valid = (push_q.size() != 0);
    bus.s_data  = (push_q.size() != 0) ? push_q[0] : '0;
  endtask

  // Advance to the next negedge, retire an accepted token and present the next one.
  task automatic tick();
    @(negedge clk);
    if (fire && push_q.size() != 0) void'(push_q.pop_front());
    feed();
  endtask

  task automatic get_token(output logic [DW-1:0] d);
    bit got = 0;
    d = '0;
    bus.req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.ack === 1'b1) begin
        d = bus.dout;
        got = 1;
      end
    end
    bus.req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL get_token_timeout: ack=%b after 20 cycles, required ack=1", bus.ack);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 1'b0;
    push_q.delete();
    feed();
    tick();
    tick();
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", bus.ack); end
    checks++; if (bus.dout !== '0) begin errors++; $display("FAIL reset_dout: got %h required 0", bus.dout); end
    checks++; if (bus.count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", bus.count); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d required 0", bus.level); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_sready_in_rst: got %b required 0", bus.s_ready); end
    rst = 1'b0;
    tick();
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_sready: got %b required 1", bus.s_ready); end
  endtask

  task automatic test_single();
    bus.req = 1'b1;
    push_q.push_back(32'h5);
    feed();
    tick();  // after push edge k
    checks++; if (bus.level !== 3'd1) begin errors++; $display("FAIL single_level_k: got %0d required 1", bus.level); end
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL single_ack_k: got %b required 0", bus.ack); end
    tick();  // after edge k+1
    checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL single_ack_k1: got %b required 1", bus.ack); end
    checks++; if (bus.dout !== 32'h5) begin errors++; $display("FAIL single_dout: got %h required 5", bus.dout); end
    checks++; if (bus.count !== 32'd1) begin errors++; $display("FAIL single_count: got %0d required 1", bus.count); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL single_level: got %0d required 0", bus.level); end
    bus.req = 1'b0;
    tick();
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL single_ack_fall: got %b required 0", bus.ack); end
    checks++; if (bus.dout !== 32'h5) begin errors++; $display("FAIL single_dout_hold: got %h required 5", bus.dout); end
  endtask

  task automatic test_full();
    logic [DW-1:0] d;
    bus.req = 1'b0;
    for (int i = 0; i < 5; i++) push_q.push_back(DW'(i));
    feed();
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d required 4", bus.level); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL full_sready: got %b required 0", bus.s_ready); end
    tick();
    checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL full_stall_level: got %0d required 4", bus.level); end
    checks++; if (push_q.size() != 1) begin errors++; $display("FAIL full_stall_pending: got %0d pending required 1", push_q.size()); end
    for (int i = 0; i < 5; i++) begin
      get_token(d);
      checks++;
      if (d !== DW'(i)) begin errors++; $display("FAIL full_order[%0d]: got %h required %h", i, d, DW'(i)); end
    end
    tick();
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL full_drain_level: got %0d required 0", bus.level); end
    checks++; if (bus.count !== 32'd6) begin errors++; $display("FAIL full_count: got %0d required 6", bus.count); end
  endtask

  // Consumer behaves as an addi(2) stage on every served token.
  task automatic test_back_to_back();
    int n = 0;
    int last_cyc = -1;
    bus.req = 1'b1;
    for (int i = 0; i < 10; i++) push_q.push_back(DW'(i));
    feed();
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      tick();
      if (bus.ack === 1'b1) begin
        checks++;
        if (bus.dout + 32'd2 !== DW'(n + 2)) begin
          errors++;
          $display("FAIL stream_val[%0d]: got %0d required %0d", n, bus.dout + 32'd2, n + 2);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 2) begin
            errors++;
            $display("FAIL stream_rate[%0d]: got spacing %0d required 2", n, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        n++;
      end
    end
    bus.req = 1'b0;
    checks++; if (n != 10) begin errors++; $display("FAIL stream_tokens: got %0d required 10", n); end
    tick();
    checks++; if (bus.count !== 32'd16) begin errors++; $display("FAIL stream_count: got %0d required 16", bus.count); end
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL stream_level: got %0d required 0", bus.level); end
  endtask

  task automatic test_push_pop();
    bus.req = 1'b0;
    push_q.push_back(32'h31);
    push_q.push_back(32'h32);
    feed();
    tick();
    tick();
    checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL pp_setup_level: got %0d required 2", bus.level); end
    bus.req = 1'b1;
    push_q.push_back(32'h77);
    feed();
    tick();  // serve 0x31 and push 0x77 on the same edge
    checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL pp_level: got %0d required 2", bus.level); end
    checks++; if (bus.ack !== 1'b1 || bus.dout !== 32'h31) begin
      errors++; $display("FAIL pp_first: got ack=%b dout=%h required ack=1 dout=31", bus.ack, bus.dout);
    end
    tick();
    tick();
    checks++; if (bus.ack !== 1'b1 || bus.dout !== 32'h32) begin
      errors++; $display("FAIL pp_second: got ack=%b dout=%h required ack=1 dout=32", bus.ack, bus.dout);
    end
    tick();
    tick();
    checks++; if (bus.ack !== 1'b1 || bus.dout !== 32'h77) begin
      errors++; $display("FAIL pp_third: got ack=%b dout=%h required ack=1 dout=77", bus.ack, bus.dout);
    end
    bus.req = 1'b0;
    checks++; if (bus.count !== 32'd19) begin errors++; $display("FAIL pp_count: got %0d required 19", bus.count); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [DW-1:0] d;
    bus.req = 1'b0;
    push_q.push_back(32'h1);
    push_q.push_back(32'h2);
    push_q.push_back(32'h3);
    feed();
    tick();
    tick();
    tick();
    checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL mid_setup_level: got %0d required 3", bus.level); end
    bus.req = 1'b1;
    tick();
    checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL mid_ack_before_rst: got %b required 1", bus.ack); end
    rst = 1'b1;
    bus.req = 1'b0;
    tick();
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL mid_level: got %0d required 0", bus.level); end
    checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL mid_ack: got %b required 0", bus.ack); end
    checks++; if (bus.count !== 32'd0) begin errors++; $display("FAIL mid_count: got %0d required 0", bus.count); end
    rst = 1'b0;
    push_q.push_back(32'hA);
    feed();
    get_token(d);
    checks++; if (d !== 32'hA) begin errors++; $display("FAIL mid_first_token: got %h required a", d); end
    checks++; if (bus.count !== 32'd1) begin errors++; $display("FAIL mid_count_after: got %0d required 1", bus.count); end
    tick();
    checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL mid_level_after: got %0d required 0", bus.level); end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.req     = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_push_pop();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
